// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low keypad matrix one row at a time, synchronizes the
//   column lines, assembles a full 16-key snapshot every four rows and
//   debounces those snapshots before publishing them on key.
//
//   Parameters
//     SCAN_DIV        clock cycles each row is driven (>= 4)
//     DEBOUNCE_SCANS  identical consecutive full scans needed before key moves (>= 1)
//
//   Ports
//     clk          system clock
//     rst_n        synchronous active-low reset
//     col_in[3:0]  raw keypad columns, pulled up, 0 = closed key on driven row
//     row_out[3:0] keypad row drive, active-low, exactly one bit low
//     key[15:0]    debounced key state, bit row*4+col set while pressed
//     key_changed  one-cycle pulse in the cycle key shows a new value
//     scan_done    one-cycle pulse marking completion of each 4-row scan
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] key,
  output logic        key_changed,
  output logic        scan_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [DIV_W-1:0] div;
  logic [1:0]       row;
  logic [3:0]       col_meta;
  logic [3:0]       col_sync;
  logic [11:0]      scan_vec;
  logic [15:0]      prev;
  logic [15:0]      cur;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sample;
  logic             scan_end;

  // The last divider cycle of a row is the sample point; the last sample of
  // row 3 closes a full scan. Row 3 is never stored in scan_vec because it is
  // consumed directly from col_sync when the snapshot is assembled.
  assign sample   = (div == DIV_LAST);
  assign scan_end = sample && (row == 2'd3);
  assign cur      = {~col_sync, scan_vec};
  assign row_out  = ~(4'b0001 << row);

  // Run length of identical snapshots, saturating so a held vector can
  // never fire key_changed a second time.
  always_comb begin
    cnt_next = cnt;
    if (cur != prev) begin
      cnt_next = CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous column lines. Reset value is
  // the idle (pulled-up) level so no phantom press is seen after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Row timing: div counts the cycles a row is driven, row advances on the
  // sample edge so the drive changes only after the column was captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
      row <= 2'd0;
    end else if (sample) begin
      div <= '0;
      row <= row + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Capture the pressed columns of rows 0..2 into the partial snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_vec <= '0;
    end else if (sample) begin
      case (row)
        2'd0:    scan_vec[3:0]  <= ~col_sync;
        2'd1:    scan_vec[7:4]  <= ~col_sync;
        2'd2:    scan_vec[11:8] <= ~col_sync;
        default: ;
      endcase
    end
  end

  // Debounce at the end of each full scan. scan_done is registered on the
  // same edge as key/key_changed so both pulses line up in one cycle and a
  // key_changed pulse is always accompanied by scan_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev        <= '0;
      cnt         <= '0;
      key         <= '0;
      key_changed <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      key_changed <= 1'b0;
      scan_done   <= scan_end;
      if (scan_end) begin
        prev <= cur;
        cnt  <= cnt_next;
        if ((cnt_next == CNT_MAX) && (cur != key)) begin
          key         <= cur;
          key_changed <= 1'b1;
        end
      end
    end
  end

endmodule
